spi_rx_oversampled: RTL and testbench
=====================================

SPI_RX_OVERSAMPLED -- requirements
Module: spi_rx_oversampled

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, meaning received word size in bits (2..32).
REQ-002 The block SHALL expose parameter DEPTH, default 4, meaning output FIFO entries (power of 2, >=2).
REQ-003 The block SHALL expose parameter CPOL, default 0, meaning SCK idle level.
REQ-004 The block SHALL expose parameter CPHA, default 0, meaning 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 The block SHALL expose parameter LSB_FIRST, default 0, meaning 0 = first bit lands in data[WIDTH-1].
REQ-006 The block SHALL have these ports (one clock; reset synchronous, active-high):
  clk  input  1  system clock, all logic on posedge
  rst  input  1  synchronous active-high reset
  spi_sck  input  1  asynchronous SPI clock from master
  spi_csn  input  1  asynchronous chip select, active low
  spi_sdi  input  1  asynchronous serial data in
  data  output  WIDTH  received word at FIFO head
  data_valid  output  1  FIFO not empty
  data_ready  input  1  consumer accepts head when data_valid && data_ready
  overflow  output  1  one-clk pulse: completed word dropped, FIFO full
  frame_err  output  1  one-clk pulse: CSN deasserted with partial word

Function
REQ-007 spi_sck, spi_csn, spi_sdi SHALL each pass a 2-flop synchronizer before use; spi_csn synchronizer SHALL reset to 1, spi_sck to CPOL.
REQ-008 Edge detection SHALL compare synchronized SCK with its one-cycle-delayed copy; leading edge = transition away from CPOL, trailing edge = transition back to CPOL.
REQ-009 Sampling edge SHALL be leading edge when CPHA=0, trailing edge when CPHA=1; edges while synchronized CSN=1 SHALL be ignored.
REQ-010 FSM SHALL have states IDLE (CSN high, bit count 0) and SHIFT (CSN low); IDLE->SHIFT on synchronized CSN falling; SHIFT->IDLE on synchronized CSN rising.
REQ-011 In SHIFT each sampling edge SHALL shift synchronized SDI into the shift register (MSB-first or LSB-first per LSB_FIRST) and increment a bit counter of width clog2(WIDTH+1).
REQ-012 On the sampling edge that makes the count WIDTH, the complete word (including that bit) SHALL be pushed next cycle and the counter SHALL wrap to 0 while staying in SHIFT, so back-to-back words under one CSN are supported.
REQ-013 Push to a full FIFO SHALL be dropped and overflow SHALL pulse for exactly one cycle, except that a simultaneous pop in the same cycle SHALL make room and the push SHALL succeed.
REQ-014 Pop SHALL occur on data_valid && data_ready; data SHALL present the next entry (or hold stale value with data_valid=0) on the following cycle.
REQ-015 CSN rising with bit count in 1..WIDTH-1 SHALL discard the partial word, clear the counter, and pulse frame_err one cycle; count 0 SHALL produce no pulse.
REQ-016 Latency from the sampling SCK pin edge of the last bit to data_valid rising (empty FIFO) SHALL be 4 clk cycles (2 sync, 1 edge detect, 1 FIFO write).
REQ-017 Correct operation SHALL be guaranteed for clk frequency >= 4x SCK frequency with SCK high and low phases each >= 2 clk periods.
REQ-018 Pushes to the FIFO SHALL be in SPI receive order; FIFO occupancy SHALL never exceed DEPTH.

Reset
REQ-019 While rst=1 the FSM SHALL be IDLE, counter 0, shift register 0, FIFO empty, data_valid=0, data=0, overflow=0, frame_err=0.
REQ-020 Reset asserted mid-word SHALL discard the partial word without frame_err; after rst falls, bits SHALL be accepted only after a fresh synchronized CSN falling edge.

Structure
REQ-021 Package spi_pkg SHALL hold the FSM state encoding and mode constants (MODE0..MODE3 as {CPOL,CPHA}) shared with the future SPI transmitter.
REQ-022 The FIFO SHALL be sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty), reusable elsewhere.

Verification
REQ-023 Mode 0, WIDTH=8, send 0xA5 MSB-first, clk=8x SCK -> data=0xA5, data_valid high 4 clk after last sampling edge.
REQ-024 CPOL=1 CPHA=1 LSB_FIRST=1, send 0x3C then 0x81 under one CSN -> two pops yielding 0x3C then 0x81, no frame_err.
REQ-025 data_ready=0, DEPTH=4, send 5 words 0x01..0x05 -> FIFO holds 0x01..0x04, overflow pulses once on 5th word.
REQ-026 Full FIFO with data_ready=1 exactly on 5th push cycle -> no overflow, 0x05 retained.
REQ-027 CSN raised after 3 bits -> frame_err one-cycle pulse, FIFO unchanged; next full byte 0x5A received correctly.
REQ-028 rst pulsed after 5 bits of a byte -> outputs at reset values, no frame_err, subsequent CSN frame 0xC3 received intact.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI FSM state encoding and mode constants
package spi_pkg;

  // Receiver/transmitter framing states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

  // SPI mode encoded as {CPOL, CPHA}
  typedef logic [1:0] spi_mode_t;

  localparam spi_mode_t MODE0 = 2'b00;
  localparam spi_mode_t MODE1 = 2'b01;
  localparam spi_mode_t MODE2 = 2'b10;
  localparam spi_mode_t MODE3 = 2'b11;

  // Idle SCK level of a mode
  function automatic logic mode_cpol(input spi_mode_t mode);
    return mode[1];
  endfunction

  // Non-zero when the mode samples on the trailing edge
  function automatic logic mode_cpha(input spi_mode_t mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push-while-full-and-pop support
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot the push needs
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_rx_oversampled.sv
// rtl/spi_rx_oversampled.sv - oversampled SPI slave receiver with output FIFO
module spi_rx_oversampled
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sck,
  input  logic             spi_csn,
  input  logic             spi_sdi,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overflow,
  output logic             frame_err
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic             SCK_IDLE = (CPOL != 0);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sck_meta, sck_s, sck_prev;
  logic csn_meta, csn_s, csn_prev;
  logic sdi_meta, sdi_s;
  logic [2:0] warm;

  logic lead_edge, trail_edge, sample_edge, csn_fall;

  spi_state_t       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shift_next;
  logic             push_pending;

  logic fifo_full, fifo_empty, pop;

  // Two-flop synchronizers, one-cycle delayed copies, and a post-reset warm-up tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_meta <= SCK_IDLE;
      sck_s    <= SCK_IDLE;
      sck_prev <= SCK_IDLE;
      csn_meta <= 1'b1;
      csn_s    <= 1'b1;
      csn_prev <= 1'b1;
      sdi_meta <= 1'b0;
      sdi_s    <= 1'b0;
      warm     <= '0;
    end else begin
      sck_meta <= spi_sck;
      sck_s    <= sck_meta;
      sck_prev <= sck_s;
      csn_meta <= spi_csn;
      csn_s    <= csn_meta;
      csn_prev <= csn_s;
      sdi_meta <= spi_sdi;
      sdi_s    <= sdi_meta;
      warm     <= {warm[1:0], 1'b1};
    end
  end

  assign lead_edge   = (sck_prev == SCK_IDLE) && (sck_s != SCK_IDLE);
  assign trail_edge  = (sck_prev != SCK_IDLE) && (sck_s == SCK_IDLE);
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  // The synchronizer reset value of 1 would look like a falling CSN if the pin is
  // already low, so a falling edge only counts once csn_prev holds a real pin sample
  assign csn_fall    = warm[2] && csn_prev && !csn_s;

  // Next shift-register value for the bit order in use
  always_comb begin
    shift_next = shreg;
    if (LSB_FIRST != 0) begin
      shift_next = {sdi_s, shreg[WIDTH-1:1]};
    end else begin
      shift_next = {shreg[WIDTH-2:0], sdi_s};
    end
  end

  // Framing FSM: shift on sampling edges, flag complete words, report partial frames
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      push_pending <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      push_pending <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (csn_fall) begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (csn_s) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            if (bit_cnt != '0) begin
              frame_err <= 1'b1;
            end
          end else if (sample_edge) begin
            shreg <= shift_next;
            if (bit_cnt == LAST_CNT) begin
              bit_cnt      <= '0;
              push_pending <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign pop        = data_valid && data_ready;
  assign data_valid = !fifo_empty;

  // Flag a completed word that found the FIFO full with no pop to make room
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= push_pending && fifo_full && !pop;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_pending),
    .push_data (shreg),
    .pop       (pop),
    .pop_data  (data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_spi_rx_oversampled.sv
// tb/tb_spi_rx_oversampled.sv - directed and randomized bench for spi_rx_oversampled
module tb_spi_rx_oversampled;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sck0, csn0, sdi0, ready0;
  logic [7:0] data0;
  logic       valid0, ovf0, fe0;
  logic       sck1, csn1, sdi1, ready1;
  logic [7:0] data1;
  logic       valid1, ovf1, fe1;

  int checks = 0;
  int errors = 0;
  int ovf_cyc0 = 0, fe_cyc0 = 0, ovf_cyc1 = 0, fe_cyc1 = 0;
  int exp_ovf0 = 0, exp_fe0 = 0;
  int nw, np;
  logic [7:0] w;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  spi_rx_oversampled #(
    .WIDTH(8), .DEPTH(4), .CPOL(0), .CPHA(0), .LSB_FIRST(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .spi_sck(sck0), .spi_csn(csn0), .spi_sdi(sdi0),
    .data(data0), .data_valid(valid0), .data_ready(ready0),
    .overflow(ovf0), .frame_err(fe0)
  );

  spi_rx_oversampled #(
    .WIDTH(8), .DEPTH(4), .CPOL(1), .CPHA(1), .LSB_FIRST(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .spi_sck(sck1), .spi_csn(csn1), .spi_sdi(sdi1),
    .data(data1), .data_valid(valid1), .data_ready(ready1),
    .overflow(ovf1), .frame_err(fe1)
  );

  // Count high cycles of the pulse outputs, sampled away from the active edge
  always @(negedge clk) begin
    if (ovf0) ovf_cyc0 <= ovf_cyc0 + 1;
    if (fe0)  fe_cyc0  <= fe_cyc0 + 1;
    if (ovf1) ovf_cyc1 <= ovf_cyc1 + 1;
    if (fe1)  fe_cyc1  <= fe_cyc1 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode 0 MSB-first on dut0; mode 3 LSB-first on dut1
  task automatic send_bits(input int m, input logic [31:0] wd, input int n);
    for (int i = 0; i < n; i++) begin
      if (m == 0) begin
        sdi0 = wd[n-1-i];
        tick(4);
        sck0 = 1'b1;
        tick(4);
        sck0 = 1'b0;
      end else begin
        sck1 = 1'b0;
        sdi1 = wd[i];
        tick(4);
        sck1 = 1'b1;
        tick(4);
      end
    end
    tick(4);
  endtask

  task automatic frame_begin(input int m);
    if (m == 0) csn0 = 1'b0; else csn1 = 1'b0;
    tick(4);
  endtask

  task automatic frame_end(input int m);
    tick(4);
    if (m == 0) csn0 = 1'b1; else csn1 = 1'b1;
    tick(8);
  endtask

  task automatic pop_check(input int m, input string tag);
    logic [7:0] e;
    e = 8'h00;
    if (m == 0) begin
      if (q0.size() > 0) e = q0.pop_front();
      chk({tag, "_valid"}, valid0, 1);
      chk({tag, "_data"}, data0, e);
      ready0 = 1'b1;
      tick(1);
      ready0 = 1'b0;
    end else begin
      if (q1.size() > 0) e = q1.pop_front();
      chk({tag, "_valid"}, valid1, 1);
      chk({tag, "_data"}, data1, e);
      ready1 = 1'b1;
      tick(1);
      ready1 = 1'b0;
    end
  endtask

  task automatic drain0(input string tag);
    while (q0.size() > 0) pop_check(0, tag);
    chk({tag, "_empty"}, valid0, 0);
  endtask

  initial begin
    rst = 1'b1;
    csn0 = 1'b1; sck0 = 1'b0; sdi0 = 1'b0; ready0 = 1'b0;
    csn1 = 1'b1; sck1 = 1'b1; sdi1 = 1'b0; ready1 = 1'b0;
    tick(4);
    chk("rst_valid0", valid0, 0);
    chk("rst_data0", data0, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_fe0", fe0, 0);
    chk("rst_valid1", valid1, 0);
    rst = 1'b0;
    tick(4);

    // 0xA5 mode 0 with latency on the final bit
    frame_begin(0);
    send_bits(0, 32'h52, 7);
    sdi0 = 1'b1;
    tick(4);
    sck0 = 1'b1;
    tick(3);
    chk("lat_early", valid0, 0);
    tick(1);
    chk("lat_valid", valid0, 1);
    chk("lat_data", data0, 8'hA5);
    q0.push_back(8'hA5);
    tick(3);
    sck0 = 1'b0;
    tick(4);
    frame_end(0);
    drain0("a5");

    // Mode 3 LSB-first, two words under one CSN
    frame_begin(1);
    send_bits(1, 32'h3C, 8);
    q1.push_back(8'h3C);
    send_bits(1, 32'h81, 8);
    q1.push_back(8'h81);
    frame_end(1);
    pop_check(1, "m3_w0");
    pop_check(1, "m3_w1");
    chk("m3_empty", valid1, 0);
    chk("m3_fe", fe_cyc1, 0);
    chk("m3_ovf", ovf_cyc1, 0);

    // Five words into a four-deep FIFO with no consumer
    frame_begin(0);
    for (int k = 1; k <= 5; k++) begin
      send_bits(0, k, 8);
      if (q0.size() < 4) q0.push_back(8'(k)); else exp_ovf0++;
    end
    frame_end(0);
    chk("ovf_cnt", ovf_cyc0, exp_ovf0);
    drain0("ovf");

    // Fifth push coinciding with a pop
    frame_begin(0);
    for (int k = 1; k <= 4; k++) begin
      send_bits(0, k, 8);
      q0.push_back(8'(k));
    end
    send_bits(0, 32'h02, 7);
    sdi0 = 1'b1;
    tick(4);
    sck0 = 1'b1;
    tick(3);
    chk("simul_head", data0, q0[0]);
    ready0 = 1'b1;
    tick(1);
    ready0 = 1'b0;
    void'(q0.pop_front());
    q0.push_back(8'h05);
    tick(3);
    sck0 = 1'b0;
    tick(4);
    frame_end(0);
    chk("simul_ovf", ovf_cyc0, exp_ovf0);
    drain0("simul");

    // Partial frame of three bits, then a good byte
    frame_begin(0);
    send_bits(0, 32'h5, 3);
    frame_end(0);
    exp_fe0++;
    chk("fe_cnt", fe_cyc0, exp_fe0);
    chk("fe_fifo", valid0, 0);
    frame_begin(0);
    send_bits(0, 32'h5A, 8);
    q0.push_back(8'h5A);
    frame_end(0);
    drain0("fe_next");
    chk("fe_after", fe_cyc0, exp_fe0);

    // Randomized frames and pops against the queue model
    for (int r = 0; r < 5; r++) begin
      nw = $urandom_range(1, 3);
      frame_begin(0);
      for (int k = 0; k < nw; k++) begin
        w = 8'($urandom);
        send_bits(0, w, 8);
        if (q0.size() < 4) q0.push_back(w); else exp_ovf0++;
      end
      frame_end(0);
      chk("rand_ovf", ovf_cyc0, exp_ovf0);
      np = $urandom_range(0, q0.size());
      repeat (np) pop_check(0, "rand_pop");
      chk("rand_valid", valid0, (q0.size() != 0) ? 1 : 0);
    end
    drain0("rand_drain");
    chk("rand_fe", fe_cyc0, exp_fe0);

    // Reset in the middle of a byte with an entry already queued
    frame_begin(0);
    send_bits(0, 32'h77, 8);
    frame_end(0);
    q0.push_back(8'h77);
    chk("prerst_valid", valid0, 1);
    frame_begin(0);
    send_bits(0, 32'h15, 5);
    rst = 1'b1;
    tick(2);
    chk("midrst_valid", valid0, 0);
    chk("midrst_data", data0, 0);
    chk("midrst_ovf", ovf0, 0);
    chk("midrst_fe", fe0, 0);
    q0.delete();
    rst = 1'b0;
    tick(2);
    send_bits(0, 32'h7, 3);
    csn0 = 1'b1;
    tick(8);
    chk("postrst_fe", fe_cyc0, exp_fe0);
    chk("postrst_valid", valid0, 0);
    frame_begin(0);
    send_bits(0, 32'hC3, 8);
    q0.push_back(8'hC3);
    frame_end(0);
    drain0("postrst");
    chk("final_fe", fe_cyc0, exp_fe0);
    chk("final_ovf", ovf_cyc0, exp_ovf0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
